mastermind_core_param: RTL and testbench

Parametrised successor to the two-player Mastermind game core. A player (the maker) enters a secret code one symbol per enter press, and the other player (the breaker) guesses within a limited number of tries. Code length, symbol width, try count, round count and win score are generic. Feedback now reports misplaced (partial) hits as well as exact hits, and the game ends on a round limit or a win score. It sits between the board-level debounced button/switch inputs and the display/LED drivers.

---
 rtl/mastermind_pkg.sv | 31 +++
 rtl/mastermind_core_param_if.sv | 48 ++++
 rtl/mastermind_eval.sv | 50 +++++
 rtl/mastermind_core_param.sv | 203 ++++++++++++++++++++
 tb/tb_mastermind_core_param.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// mastermind_pkg
// Shared types and helpers for the parametrised Mastermind game core.
//   state_t  : game controller states
//   winner_t : encoding driven on the winner output
//   therm_bit: one bit of a thermometer code (bit pos is set when pos < count)
package mastermind_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MAKER     = 3'd1,
      BREAKER   = 3'd2,
      EVAL      = 3'd3,
      ROUND_END = 3'd4,
      DONE      = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_A    = 2'b01,
      WIN_B    = 2'b10,
      WIN_TIE  = 2'b11
   } winner_t;

   // A thermometer code of value n has its n lowest bits set. The encoder is
   // expressed per bit so callers can build a field of any width without
   // carrying unused upper bits around.
   function automatic logic therm_bit(input int count, input int pos);
      return (pos < count);
   endfunction

endpackage

// File: rtl/mastermind_core_param_if.sv
// mastermind_core_param_if
// Groups the board-side signals of the Mastermind core.
//   enterA/enterB    : debounced enter buttons (levels)
//   SW               : symbol selected on the switches
//   round_count_disp : completed rounds
//   scoreA_disp/scoreB_disp : player scores
//   tries_left       : guesses remaining this round
//   leds_debug       : secret register, symbol 0 in the MSBs
//   led_feedback     : {exact thermometer, partial thermometer}
//   maker_is_b, game_over, winner : game status
// Modport master is the board side, slave is the core.
interface mastermind_core_param_if #(
   parameter int CODE_LEN  = 4,
   parameter int SYM_W     = 3,
   parameter int MAX_TRIES = 3,
   parameter int ROUNDS    = 4,
   parameter int WIN_SCORE = 3
);
   localparam int RW  = $clog2(ROUNDS + 1);
   localparam int SCW = $clog2(WIN_SCORE + 1);
   localparam int TW  = $clog2(MAX_TRIES + 1);

   logic                      enterA;
   logic                      enterB;
   logic [SYM_W-1:0]          SW;
   logic [RW-1:0]             round_count_disp;
   logic [SCW-1:0]            scoreA_disp;
   logic [SCW-1:0]            scoreB_disp;
   logic [TW-1:0]             tries_left;
   logic [CODE_LEN*SYM_W-1:0] leds_debug;
   logic [2*CODE_LEN-1:0]     led_feedback;
   logic                      maker_is_b;
   logic                      game_over;
   logic [1:0]                winner;

   modport master (
      output enterA, enterB, SW,
      input  round_count_disp, scoreA_disp, scoreB_disp, tries_left,
             leds_debug, led_feedback, maker_is_b, game_over, winner
   );

   modport slave (
      input  enterA, enterB, SW,
      output round_count_disp, scoreA_disp, scoreB_disp, tries_left,
             leds_debug, led_feedback, maker_is_b, game_over, winner
   );

endinterface

// File: rtl/mastermind_eval.sv
// mastermind_eval
// Purely combinational scoring of a guess against the secret.
//   secret, guess : CODE_LEN symbols of SYM_W bits, symbol 0 in the MSBs
//   exact         : positions where guess equals secret
//   partial       : right symbol in the wrong position
// Partial hits come from per-symbol histograms: the number of matched symbols
// regardless of position is the sum over the alphabet of min(count in secret,
// count in guess); removing the exact hits leaves the misplaced ones.
module mastermind_eval #(
   parameter int CODE_LEN = 4,
   parameter int SYM_W    = 3,
   localparam int CW      = $clog2(CODE_LEN + 1)
) (
   input  logic [0:CODE_LEN-1][SYM_W-1:0] secret,
   input  logic [0:CODE_LEN-1][SYM_W-1:0] guess,
   output logic [CW-1:0]                  exact,
   output logic [CW-1:0]                  partial
);
   localparam int NSYM = 1 << SYM_W;

   logic [CW-1:0] exact_cnt;
   logic [CW-1:0] match_sum;
   logic [CW-1:0] sec_cnt;
   logic [CW-1:0] gue_cnt;

   // Count exact positions, then histogram each symbol of the alphabet and
   // accumulate the smaller of the two counts.
   always_comb begin
      exact_cnt = '0;
      match_sum = '0;
      sec_cnt   = '0;
      gue_cnt   = '0;
      for (int p = 0; p < CODE_LEN; p++) begin
         if (secret[p] == guess[p]) exact_cnt = exact_cnt + CW'(1);
      end
      for (int s = 0; s < NSYM; s++) begin
         sec_cnt = '0;
         gue_cnt = '0;
         for (int p = 0; p < CODE_LEN; p++) begin
            if (secret[p] == SYM_W'(s)) sec_cnt = sec_cnt + CW'(1);
            if (guess[p] == SYM_W'(s))  gue_cnt = gue_cnt + CW'(1);
         end
         match_sum = match_sum + ((sec_cnt < gue_cnt) ? sec_cnt : gue_cnt);
      end
   end

   assign exact   = exact_cnt;
   assign partial = match_sum - exact_cnt;

endmodule

// File: rtl/mastermind_core_param.sv
// mastermind_core_param
// Two-player Mastermind game controller. The maker enters a secret one symbol
// per press, the breaker guesses with limited tries, and the game runs until
// the round limit or a win score is reached.
//   clk   : system clock
//   reset : synchronous, active-low
//   io    : board-side interface (slave modport): enter buttons, switches,
//           score/round/tries displays, feedback LEDs and game status
module mastermind_core_param
   import mastermind_pkg::*;
#(
   parameter int CODE_LEN  = 4,
   parameter int SYM_W     = 3,
   parameter int MAX_TRIES = 3,
   parameter int ROUNDS    = 4,
   parameter int WIN_SCORE = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   mastermind_core_param_if.slave   io
);
   localparam int CW  = $clog2(CODE_LEN + 1);
   localparam int IW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int RW  = $clog2(ROUNDS + 1);
   localparam int SCW = $clog2(WIN_SCORE + 1);
   localparam int TW  = $clog2(MAX_TRIES + 1);

   typedef logic [0:CODE_LEN-1][SYM_W-1:0] code_t;

   state_t                state;
   logic                  prev_a;
   logic                  prev_b;
   logic [IW-1:0]         idx;
   code_t                 secret;
   code_t                 guess;
   logic [TW-1:0]         tries;
   logic [RW-1:0]         round_cnt;
   logic [SCW-1:0]        score_a;
   logic [SCW-1:0]        score_b;
   logic                  maker_b;
   logic                  over;
   winner_t               win;
   logic [2*CODE_LEN-1:0] feedback;

   logic                  press_a;
   logic                  press_b;
   logic                  maker_press;
   logic                  breaker_press;
   logic                  last_idx;
   logic [CW-1:0]         exact_cnt;
   logic [CW-1:0]         partial_cnt;
   logic [2*CODE_LEN-1:0] fb_next;
   logic [TW-1:0]         tries_dec;
   logic [RW-1:0]         round_inc;
   logic [SCW-1:0]        score_a_inc;
   logic [SCW-1:0]        score_b_inc;
   logic                  game_ends;
   winner_t               win_next;

   mastermind_eval #(
      .CODE_LEN (CODE_LEN),
      .SYM_W    (SYM_W)
   ) u_eval (
      .secret  (secret),
      .guess   (guess),
      .exact   (exact_cnt),
      .partial (partial_cnt)
   );

   assign press_a       = io.enterA & ~prev_a;
   assign press_b       = io.enterB & ~prev_b;
   assign maker_press   = maker_b ? press_b : press_a;
   assign breaker_press = maker_b ? press_a : press_b;
   assign last_idx      = (idx == IW'(CODE_LEN - 1));
   assign tries_dec     = tries - TW'(1);

   // Saturating increments and the end-of-game decision. The round limit is
   // judged on the count this ROUND_END is about to write; the scores were
   // already updated during the preceding EVAL cycle.
   always_comb begin
      round_inc   = (round_cnt < RW'(ROUNDS))   ? round_cnt + RW'(1)  : round_cnt;
      score_a_inc = (score_a < SCW'(WIN_SCORE)) ? score_a + SCW'(1)   : score_a;
      score_b_inc = (score_b < SCW'(WIN_SCORE)) ? score_b + SCW'(1)   : score_b;
      game_ends   = (round_inc == RW'(ROUNDS)) ||
                    (score_a == SCW'(WIN_SCORE)) || (score_b == SCW'(WIN_SCORE));
      if (score_a > score_b)      win_next = WIN_A;
      else if (score_b > score_a) win_next = WIN_B;
      else                        win_next = WIN_TIE;
   end

   // Feedback LEDs: exact-hit thermometer in the upper half, partial-hit
   // thermometer in the lower half.
   always_comb begin
      fb_next = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         fb_next[CODE_LEN + i] = therm_bit(int'(exact_cnt), i);
         fb_next[i]            = therm_bit(int'(partial_cnt), i);
      end
   end

   // Game controller. Every output is a register written here; presses that
   // land in EVAL, ROUND_END or DONE simply fall through without effect.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         prev_a    <= 1'b0;
         prev_b    <= 1'b0;
         idx       <= '0;
         secret    <= '0;
         guess     <= '0;
         tries     <= '0;
         round_cnt <= '0;
         score_a   <= '0;
         score_b   <= '0;
         maker_b   <= 1'b0;
         over      <= 1'b0;
         win       <= WIN_NONE;
         feedback  <= '0;
      end else begin
         prev_a <= io.enterA;
         prev_b <= io.enterB;
         case (state)
            IDLE: begin
               if (press_a || press_b) begin
                  maker_b <= ~press_a;
                  tries   <= TW'(MAX_TRIES);
                  idx     <= '0;
                  state   <= MAKER;
               end
            end
            MAKER: begin
               if (maker_press) begin
                  secret[idx] <= io.SW;
                  if (last_idx) begin
                     idx   <= '0;
                     state <= BREAKER;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            BREAKER: begin
               if (breaker_press) begin
                  guess[idx] <= io.SW;
                  if (idx == '0) feedback <= '0;
                  if (last_idx) begin
                     idx   <= '0;
                     state <= EVAL;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            EVAL: begin
               feedback <= fb_next;
               tries    <= tries_dec;
               idx      <= '0;
               if (exact_cnt == CW'(CODE_LEN)) begin
                  if (maker_b) score_a <= score_a_inc;
                  else         score_b <= score_b_inc;
                  state <= ROUND_END;
               end else if (tries_dec == '0) begin
                  if (maker_b) score_b <= score_b_inc;
                  else         score_a <= score_a_inc;
                  state <= ROUND_END;
               end else begin
                  state <= BREAKER;
               end
            end
            ROUND_END: begin
               round_cnt <= round_inc;
               maker_b   <= ~maker_b;
               tries     <= TW'(MAX_TRIES);
               secret    <= '0;
               if (game_ends) begin
                  over  <= 1'b1;
                  win   <= win_next;
                  state <= DONE;
               end else begin
                  state <= MAKER;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign io.round_count_disp = round_cnt;
   assign io.scoreA_disp      = score_a;
   assign io.scoreB_disp      = score_b;
   assign io.tries_left       = tries;
   assign io.leds_debug       = secret;
   assign io.led_feedback     = feedback;
   assign io.maker_is_b       = maker_b;
   assign io.game_over        = over;
   assign io.winner           = win;

endmodule

// File: tb/tb_mastermind_core_param.sv
// tb_mastermind_core_param
// Directed game scenarios followed by a randomized game session for the
// Mastermind core. A game-level model (phases, scores, a greedy hit matcher)
// predicts every output after each press.
module tb_mastermind_core_param;

   localparam int L      = 4;
   localparam int SYMB   = 3;
   localparam int MT     = 3;
   localparam int RN     = 4;
   localparam int WS     = 3;
   localparam int NSYM   = 1 << SYMB;

   localparam int PH_IDLE  = 0;
   localparam int PH_MAKE  = 1;
   localparam int PH_BREAK = 2;
   localparam int PH_DONE  = 3;

   logic clk = 1'b0;
   logic reset;

   int n_checks = 0;
   int n_fails  = 0;

   int m_phase, m_maker_b, m_tries, m_round, m_sa, m_sb, m_pos;
   int m_fb, m_over, m_winner;
   int m_secret[L];
   int m_guess[L];

   mastermind_core_param_if #(
      .CODE_LEN(L), .SYM_W(SYMB), .MAX_TRIES(MT), .ROUNDS(RN), .WIN_SCORE(WS)
   ) bus ();

   mastermind_core_param #(
      .CODE_LEN(L), .SYM_W(SYMB), .MAX_TRIES(MT), .ROUNDS(RN), .WIN_SCORE(WS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset;
      m_phase = PH_IDLE; m_maker_b = 0; m_tries = 0; m_round = 0;
      m_sa = 0; m_sb = 0; m_pos = 0; m_fb = 0; m_over = 0; m_winner = 0;
      for (int i = 0; i < L; i++) begin
         m_secret[i] = 0;
         m_guess[i]  = 0;
      end
   endtask

   task automatic modelEndRound;
      if (m_round < RN) m_round++;
      m_maker_b = 1 - m_maker_b;
      m_tries   = MT;
      for (int i = 0; i < L; i++) m_secret[i] = 0;
      m_pos = 0;
      if (m_round == RN || m_sa == WS || m_sb == WS) begin
         m_phase  = PH_DONE;
         m_over   = 1;
         m_winner = (m_sa > m_sb) ? 1 : (m_sb > m_sa) ? 2 : 3;
      end else begin
         m_phase = PH_MAKE;
      end
   endtask

   // Scores a complete guess: exact positions first, then each remaining guess
   // symbol claims one still-unclaimed secret symbol of the same value.
   task automatic modelScore;
      int e, pp;
      bit used[L];
      bit hit[L];
      bit found;
      e = 0; pp = 0;
      for (int i = 0; i < L; i++) begin
         hit[i]  = (m_secret[i] == m_guess[i]);
         used[i] = hit[i];
         if (hit[i]) e++;
      end
      for (int i = 0; i < L; i++) begin
         found = 0;
         if (!hit[i]) begin
            for (int j = 0; j < L; j++) begin
               if (!found && !used[j] && m_secret[j] == m_guess[i]) begin
                  used[j] = 1;
                  found   = 1;
                  pp++;
               end
            end
         end
      end
      m_fb = (((1 << e) - 1) << L) | ((1 << pp) - 1);
      m_tries--;
      if (e == L) begin
         if (m_maker_b == 1) begin if (m_sa < WS) m_sa++; end
         else                begin if (m_sb < WS) m_sb++; end
         modelEndRound();
      end else if (m_tries == 0) begin
         if (m_maker_b == 1) begin if (m_sb < WS) m_sb++; end
         else                begin if (m_sa < WS) m_sa++; end
         modelEndRound();
      end else begin
         m_pos = 0;
      end
   endtask

   // p: 0 = player A, 1 = player B.
   task automatic modelPress(input int p, input int sym);
      case (m_phase)
         PH_IDLE: begin
            m_maker_b = p; m_tries = MT; m_phase = PH_MAKE; m_pos = 0;
         end
         PH_MAKE: if (p == m_maker_b) begin
            m_secret[m_pos] = sym;
            m_pos++;
            if (m_pos == L) begin m_pos = 0; m_phase = PH_BREAK; end
         end
         PH_BREAK: if (p != m_maker_b) begin
            if (m_pos == 0) m_fb = 0;
            m_guess[m_pos] = sym;
            m_pos++;
            if (m_pos == L) modelScore();
         end
         default: ;
      endcase
   endtask

   // who: 1 = A, 2 = B, 3 = both (only meaningful in IDLE, where A wins).
   // The extra cycles let EVAL and ROUND_END complete before checking.
   task automatic applyStimulus(input int who, input int sym);
      bus.SW     = SYMB'(sym);
      bus.enterA = (who == 1 || who == 3);
      bus.enterB = (who == 2 || who == 3);
      tick;
      bus.enterA = 1'b0;
      bus.enterB = 1'b0;
      tick;
      tick;
      modelPress((who == 2) ? 1 : 0, sym);
   endtask

   task automatic checkAll(input string tag);
      logic [31:0] exp_code;
      exp_code = '0;
      for (int i = 0; i < L; i++) exp_code = (exp_code << SYMB) | 32'(m_secret[i]);
      checkOutput({tag, "/round"},  32'(bus.round_count_disp), 32'(m_round));
      checkOutput({tag, "/scoreA"}, 32'(bus.scoreA_disp),      32'(m_sa));
      checkOutput({tag, "/scoreB"}, 32'(bus.scoreB_disp),      32'(m_sb));
      checkOutput({tag, "/tries"},  32'(bus.tries_left),       32'(m_tries));
      checkOutput({tag, "/secret"}, 32'(bus.leds_debug),       exp_code);
      checkOutput({tag, "/fb"},     32'(bus.led_feedback),     32'(m_fb));
      checkOutput({tag, "/makerB"}, 32'(bus.maker_is_b),       32'(m_maker_b));
      checkOutput({tag, "/over"},   32'(bus.game_over),        32'(m_over));
      checkOutput({tag, "/winner"}, 32'(bus.winner),           32'(m_winner));
   endtask

   task automatic doReset(input string tag);
      bus.enterA = 1'b0;
      bus.enterB = 1'b0;
      reset = 1'b0;
      tick;
      modelReset();
      checkAll(tag);
      reset = 1'b1;
      tick;
   endtask

   task automatic enterCode(input int who, input int a, input int b, input int c,
                            input int d, input string tag);
      int code[4];
      code = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(who, code[i]);
         checkAll(tag);
      end
   endtask

   task automatic runScenario1(input string tag);
      applyStimulus(1, 0);
      checkAll({tag, "_start"});
      enterCode(1, 4, 1, 2, 3, {tag, "_secret"});
      enterCode(2, 4, 1, 2, 3, {tag, "_guess"});
      checkOutput({tag, "_fb_lit"},     32'(bus.led_feedback), 32'h0F0);
      checkOutput({tag, "_scoreB_lit"}, 32'(bus.scoreB_disp),  32'd1);
      checkOutput({tag, "_round_lit"},  32'(bus.round_count_disp), 32'd1);
      checkOutput({tag, "_makerB_lit"}, 32'(bus.maker_is_b),   32'd1);
   endtask

   initial begin
      int who, sym, relevant;
      reset      = 1'b0;
      bus.enterA = 1'b0;
      bus.enterB = 1'b0;
      bus.SW     = '0;
      modelReset();

      // Scenario 1: reset, A makes, B cracks the code first time.
      doReset("s1_reset");
      runScenario1("s1");

      // Scenario 2: B makes 7777, A misses three times.
      enterCode(2, 7, 7, 7, 7, "s2_secret");
      for (int t = 0; t < 3; t++) begin
         enterCode(1, 1, 1, 1, 1, "s2_guess");
         checkOutput("s2_fb_lit", 32'(bus.led_feedback), 32'h000);
         if (t < 2) checkOutput("s2_tries_lit", 32'(bus.tries_left), 32'(2 - t));
      end
      checkOutput("s2_scoreB_lit", 32'(bus.scoreB_disp), 32'd2);
      checkOutput("s2_round_lit",  32'(bus.round_count_disp), 32'd2);
      checkOutput("s2_makerB_lit", 32'(bus.maker_is_b), 32'd0);

      // Scenario 3: all-misplaced and mixed feedback, then round-limit end.
      enterCode(1, 1, 2, 3, 4, "s3_secretA");
      enterCode(2, 4, 3, 2, 1, "s3_guessB");
      checkOutput("s3_fb0F_lit", 32'(bus.led_feedback), 32'h00F);
      enterCode(2, 5, 5, 5, 5, "s3_missB");
      enterCode(2, 5, 5, 5, 5, "s3_missB");
      enterCode(2, 1, 1, 2, 2, "s3_secretB");
      enterCode(1, 1, 2, 1, 3, "s3_guessA");
      checkOutput("s3_fb13_lit", 32'(bus.led_feedback), 32'h013);
      enterCode(1, 1, 1, 2, 2, "s3_winA");
      checkOutput("s3_over_lit",   32'(bus.game_over), 32'd1);
      checkOutput("s3_winner_lit", 32'(bus.winner),    32'd3);

      // Scenario 4: simultaneous start, ignored breaker press, held enter.
      doReset("s4_reset");
      applyStimulus(3, 0);
      checkAll("s4_both");
      checkOutput("s4_makerA_lit", 32'(bus.maker_is_b), 32'd0);
      applyStimulus(2, 5);
      checkAll("s4_bInMaker");
      checkOutput("s4_secret0_lit", 32'(bus.leds_debug), 32'h000);
      bus.SW     = 3'd6;
      bus.enterA = 1'b1;
      for (int c = 0; c < 5; c++) tick;
      bus.enterA = 1'b0;
      tick;
      modelPress(0, 6);
      checkAll("s4_hold");
      checkOutput("s4_hold_lit", 32'(bus.leds_debug), 32'hC00);

      // Scenario 5: reset in the middle of a guess, then replay scenario 1.
      applyStimulus(1, 1);
      applyStimulus(1, 2);
      applyStimulus(1, 3);
      checkAll("s5_secret");
      applyStimulus(2, 6);
      applyStimulus(2, 1);
      bus.SW     = 3'd3;
      bus.enterB = 1'b1;
      reset      = 1'b0;
      tick;
      modelReset();
      checkAll("s5_midreset");
      checkOutput("s5_fb_lit", 32'(bus.led_feedback), 32'h000);
      bus.enterB = 1'b0;
      reset      = 1'b1;
      tick;
      runScenario1("s5_replay");

      // Scenario 6: B reaches the win score after three rounds.
      doReset("s6_reset");
      applyStimulus(1, 0);
      enterCode(1, 2, 4, 6, 0, "s6_r1secret");
      enterCode(2, 2, 4, 6, 0, "s6_r1guess");
      enterCode(2, 3, 3, 3, 3, "s6_r2secret");
      for (int t = 0; t < 3; t++) enterCode(1, 0, 0, 0, 0, "s6_r2guess");
      enterCode(1, 5, 5, 1, 1, "s6_r3secret");
      enterCode(2, 5, 5, 1, 1, "s6_r3guess");
      checkOutput("s6_over_lit",   32'(bus.game_over), 32'd1);
      checkOutput("s6_winner_lit", 32'(bus.winner),    32'd2);
      checkOutput("s6_round_lit",  32'(bus.round_count_disp), 32'd3);
      for (int k = 0; k < 6; k++) begin
         applyStimulus((k % 2) + 1, $urandom_range(0, NSYM - 1));
         checkAll("s6_ignored");
      end

      // Randomized session: presses mostly by the player who is expected to
      // act, guesses sometimes copied from the secret so rounds get won.
      doReset("rnd_reset");
      for (int it = 0; it < 600; it++) begin
         if ($urandom_range(0, 99) < 2 || (m_phase == PH_DONE && $urandom_range(0, 9) == 0)) begin
            doReset("rnd_reset");
         end else begin
            relevant = (m_phase == PH_MAKE)  ? m_maker_b + 1 :
                       (m_phase == PH_BREAK) ? 2 - m_maker_b : $urandom_range(1, 2);
            who = ($urandom_range(0, 9) < 8) ? relevant : 3 - relevant;
            sym = $urandom_range(0, NSYM - 1);
            if (m_phase == PH_BREAK && who == relevant && $urandom_range(0, 2) != 0)
               sym = m_secret[m_pos];
            applyStimulus(who, sym);
            checkAll("rnd");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
